btn_conditioner: RTL and testbench

Input conditioning stage for the two player buttons of the drops game, upstream of `get_input`. It synchronises the raw `ui_in[0]` (right) and `ui_in[1]` (left) pins, debounces each one, and turns each debounced press into a single pending move event. The event is held until the consumer acknowledges it with `take_i`. An optional auto-repeat mode generates repeated events while a button is held.

---
 rtl/drops_pkg.sv | 13 +
 rtl/btn_conditioner_if.sv | 19 +
 rtl/btn_channel.sv | 91 +++++++++
 rtl/btn_conditioner.sv | 61 ++++++
 tb/tb_btn_conditioner.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/drops_pkg.sv
// Shared types and defaults for the drops game input path.
package drops_pkg;
  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } btn_state_t;

  localparam int DB_CYCLES_DEF  = 16;
  localparam int REP_DELAY_DEF  = 64;
  localparam int REP_PERIOD_DEF = 16;
endpackage

// File: rtl/btn_conditioner_if.sv
// Raw button inputs, consume strobe and pending-move outputs of btn_conditioner.
interface btn_conditioner_if;
  logic       right_i;
  logic       left_i;
  logic       take_i;
  logic       right_o;
  logic       left_o;
  logic       valid_o;
  logic [1:0] held_o;

  modport master (
    input  right_i, left_i, take_i,
    output right_o, left_o, valid_o, held_o
  );
  modport slave (
    output right_i, left_i, take_i,
    input  right_o, left_o, valid_o, held_o
  );
endinterface

// File: rtl/btn_channel.sv
// One button: 2-flop synchroniser, debounce FSM, press strobe.
// BTN_AUTO_REPEAT_EN adds repeat strobes while the button stays held.
module btn_channel
  import drops_pkg::*;
#(
  parameter int DB_CYCLES  = DB_CYCLES_DEF,
  parameter int REP_DELAY  = REP_DELAY_DEF,
  parameter int REP_PERIOD = REP_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic strobe_o,
  output logic held_o
);
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  if (DB_CYCLES < 2 || REP_PERIOD < 1 || REP_PERIOD > REP_DELAY) begin : g_bad_param
    $error("btn_channel: illegal parameter combination");
  end

  logic [1:0]    sync;
  logic          btn;
  btn_state_t    state;
  logic [CW-1:0] cnt;
  logic          press_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b00;
    else        sync <= {sync[0], btn_i};
  end
  assign btn = sync[1];

  // Strobe is decoded from the accepting transition so the event flag lands on the same edge.
  assign press_done = (state == PRESS_WAIT) && btn && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (btn) begin
          state <= PRESS_WAIT;
          cnt   <= '0;
        end
        PRESS_WAIT: begin
          if (!btn)                 state <= IDLE;
          else if (cnt == CNT_LAST) state <= HELD;
          else                      cnt   <= cnt + CW'(1);
        end
        HELD: if (!btn) begin
          state <= RELEASE_WAIT;
          cnt   <= '0;
        end
        RELEASE_WAIT: begin
          if (btn)                  state <= HELD;
          else if (cnt == CNT_LAST) state <= IDLE;
          else                      cnt   <= cnt + CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign held_o = (state == HELD) || (state == RELEASE_WAIT);

`ifdef BTN_AUTO_REPEAT_EN
  localparam int RW = $clog2(REP_DELAY + 1);
  localparam logic [RW-1:0] REP_LAST   = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] REP_RELOAD = RW'(REP_DELAY - REP_PERIOD);

  logic [RW-1:0] rep_cnt;
  logic          rep_fire;

  assign rep_fire = (state == HELD) && btn && (rep_cnt == REP_LAST);

  // Reloading to DELAY-PERIOD makes later repeats fall every REP_PERIOD cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       rep_cnt <= '0;
    else if (state != HELD || !btn)   rep_cnt <= '0;
    else if (rep_fire)                rep_cnt <= REP_RELOAD;
    else                              rep_cnt <= rep_cnt + RW'(1);
  end

  assign strobe_o = press_done | rep_fire;
`else
  assign strobe_o = press_done;
`endif
endmodule

// File: rtl/btn_conditioner.sv
// Two debounced button channels feeding a single pending-move register.
// Build with BTN_AUTO_REPEAT_EN for auto-repeat while a button is held.
module btn_conditioner
  import drops_pkg::*;
#(
  parameter int DB_CYCLES  = DB_CYCLES_DEF,
  parameter int REP_DELAY  = REP_DELAY_DEF,
  parameter int REP_PERIOD = REP_PERIOD_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  btn_conditioner_if.master  bus
);
  localparam int NUM_BTN = 2;

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] strobe;
  logic [NUM_BTN-1:0] held;
  logic               right_q;
  logic               left_q;

  // Bit 0 = right, bit 1 = left, matching held_o ordering.
  assign raw = {bus.left_i, bus.right_i};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_channel #(
      .DB_CYCLES (DB_CYCLES),
      .REP_DELAY (REP_DELAY),
      .REP_PERIOD(REP_PERIOD)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_i   (raw[i]),
      .strobe_o(strobe[i]),
      .held_o  (held[i])
    );
  end

  // A fresh strobe outranks take_i; simultaneous strobes cancel each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      right_q <= 1'b0;
      left_q  <= 1'b0;
    end else begin
      case (strobe)
        2'b01: begin right_q <= 1'b1; left_q <= 1'b0; end
        2'b10: begin right_q <= 1'b0; left_q <= 1'b1; end
        2'b11: begin right_q <= 1'b0; left_q <= 1'b0; end
        default: if (bus.take_i) begin
          right_q <= 1'b0;
          left_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.right_o = right_q;
  assign bus.left_o  = left_q;
  assign bus.valid_o = right_q | left_q;
  assign bus.held_o  = held;
endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboarded bench for btn_conditioner with DB_CYCLES=4, REP_DELAY=8, REP_PERIOD=4.
module tb_btn_conditioner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  btn_conditioner_if bus();

  btn_conditioner #(
    .DB_CYCLES (4),
    .REP_DELAY (8),
    .REP_PERIOD(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int         lat;
    logic [1:0] dir;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_evt(input int lat, input logic [1:0] dir);
    exp_t e;
    e.lat = lat;
    e.dir = dir;
    sb.push_back(e);
  endtask

  // Waits (bounded) for the pending vector to change, then scores latency and direction.
  task automatic wait_evt(input string tag, input int n0);
    logic [1:0] prev;
    int         n;
    exp_t       e;
    prev = {bus.left_o, bus.right_o};
    n = n0;
    while ({bus.left_o, bus.right_o} == prev && n < 64) begin
      tick();
      n++;
    end
    e = sb.pop_front();
    chk({tag, "_lat"}, n, e.lat);
    chk({tag, "_dir"}, {30'd0, bus.left_o, bus.right_o}, {30'd0, e.dir});
  endtask

  task automatic take();
    bus.take_i = 1'b1;
    tick();
    bus.take_i = 1'b0;
  endtask

  task automatic release_all();
    bus.right_i = 1'b0;
    bus.left_i  = 1'b0;
    take();
    repeat (10) tick();
    take();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pat[5];
    int gaps[4];
    pat  = '{1, 0, 1, 1, 0};
    gaps = '{8, 4, 4, 4};
    bus.right_i = 1'b0;
    bus.left_i  = 1'b0;
    bus.take_i  = 1'b0;
    repeat (2) tick();
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_held", bus.held_o, 0);
    rst_n = 1'b1;

    // clean press
    bus.right_i = 1'b1;
    expect_evt(7, 2'b01);
    wait_evt("press", 0);
    chk("press_held", bus.held_o, 2'b01);
    repeat (5) tick();
    chk("press_hold", bus.right_o, 1);
    take();
    chk("take_clr", bus.valid_o, 0);
`ifndef BTN_AUTO_REPEAT_EN
    repeat (12) tick();
    chk("no_repeat", bus.valid_o, 0);
    take();
    chk("take_empty", bus.valid_o, 0);
`endif

    // reset mid-operation with the button still held
    release_all();
    bus.right_i = 1'b1;
    expect_evt(7, 2'b01);
    wait_evt("pre_rst", 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_right", bus.right_o, 0);
    chk("rst_async_valid", bus.valid_o, 0);
    chk("rst_async_held", bus.held_o, 0);
    tick();
    rst_n = 1'b1;
    expect_evt(7, 2'b01);
    wait_evt("rst_rel", 0);

    // bounce
    release_all();
    foreach (pat[i]) begin
      bus.right_i = pat[i][0];
      tick();
    end
    chk("bounce_quiet", bus.valid_o, 0);
    bus.right_i = 1'b1;
    expect_evt(12, 2'b01);
    wait_evt("bounce", 5);
    take();
`ifndef BTN_AUTO_REPEAT_EN
    repeat (10) tick();
    chk("bounce_once", bus.valid_o, 0);
`endif

    // override: most recent direction wins
    release_all();
    bus.left_i = 1'b1;
    expect_evt(7, 2'b10);
    wait_evt("ovr_left", 0);
    bus.right_i = 1'b1;
    expect_evt(7, 2'b01);
    wait_evt("ovr_right", 0);

    // conflict: both pressed on the same edge
    release_all();
    bus.left_i  = 1'b1;
    bus.right_i = 1'b1;
    repeat (10) tick();
    chk("conf_valid", bus.valid_o, 0);
    chk("conf_held", bus.held_o, 2'b11);

    // take on the same edge as a new left strobe
    release_all();
    bus.right_i = 1'b1;
    expect_evt(7, 2'b01);
    wait_evt("col_right", 0);
    bus.left_i = 1'b1;
    repeat (6) tick();
    chk("col_pre_right", bus.right_o, 1);
    take();
    chk("col_left", bus.left_o, 1);
    chk("col_right_clr", bus.right_o, 0);

`ifdef BTN_AUTO_REPEAT_EN
    release_all();
    bus.right_i = 1'b1;
    expect_evt(7, 2'b01);
    wait_evt("rep0", 0);
    foreach (gaps[i]) begin
      take();
      expect_evt(gaps[i], 2'b01);
      wait_evt("rep", 1);
    end
    bus.right_i = 1'b0;
    take();
    repeat (20) tick();
    chk("rep_stop", bus.valid_o, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
